// File: rtl/mips_pkg.sv
// Shared definitions for the execute-stage multiply sequencer.
//   WIDTH      : datapath width of the MIPS core
//   state_t    : sequencer states
//   BOOTH_ADD  : {Q[0],Q_1} pair that adds the multiplicand
//   BOOTH_SUB  : {Q[0],Q_1} pair that subtracts the multiplicand
package mips_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration (combinational).
// Ports:
//   a, q, q_1   : current accumulator (WIDTH+1), multiplier shift reg, guard bit
//   m           : sign-extended multiplicand (WIDTH+1)
//   a_next, q_next, q_1_next : values after add/sub and arithmetic right shift
module booth_step
   import mips_pkg::*;
#(
   parameter int WIDTH = mips_pkg::WIDTH
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic             q_1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q_1_next
);

   logic [WIDTH:0] sum;

   always_comb begin
      case ({q[0], q_1})
         BOOTH_ADD: sum = a + m;
         BOOTH_SUB: sum = a - m;
         default:   sum = a;
      endcase
      // Arithmetic shift of {A,Q,Q_1}: A's sign bit is replicated, A's LSB
      // moves into Q's MSB and Q's LSB becomes the new guard bit.
      a_next   = {sum[WIDTH], sum[WIDTH:1]};
      q_next   = {sum[0], q[WIDTH-1:1]};
      q_1_next = q[0];
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Multi-cycle signed Booth multiply sequencer with HI/LO result registers.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for MULT; MTHI/MTLO may write hi/lo
// RUN   | one Booth step per clock, pipeline stalled
// DONE  | product committed to hi/lo, done pulse; start here reloads
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start, multiplicand, multiplier : MULT issue with rs/rt operands
//   flush               : aborts an in-flight multiply, blocks a load
//   hi_we, lo_we, wdata : MTHI/MTLO writes (honoured in IDLE only)
//   stall, busy, done   : pipeline hold, sequencer active, commit pulse
//   hi, lo              : HI/LO registers
module booth_mult_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = mips_pkg::WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH:0]   a, m, a_step;
   logic [WIDTH-1:0] q, q_step;
   logic             q_1, q_1_step;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             last_step;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a        (a),
      .q        (q),
      .q_1      (q_1),
      .m        (m),
      .a_next   (a_step),
      .q_next   (q_step),
      .q_1_next (q_1_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start && !flush) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (flush)                 state_next = IDLE;
            else if (cnt == LAST_CNT)  state_next = DONE;
         end
         DONE: begin
            if (start && !flush) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign last_step = (state == RUN) && !flush && (cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a   <= '0;
         q   <= '0;
         q_1 <= 1'b0;
         m   <= '0;
         cnt <= '0;
      end else if (load) begin
         a   <= '0;
         q   <= multiplier;
         q_1 <= 1'b0;
         m   <= {multiplicand[WIDTH-1], multiplicand};
         cnt <= '0;
      end else if (state == RUN && !flush) begin
         a   <= a_step;
         q   <= q_step;
         q_1 <= q_1_step;
         cnt <= cnt + CNT_W'(1);
      end
   end

   // The product is taken from the final step's outputs so hi/lo change on
   // the same edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (last_step) begin
         hi <= a_step[WIDTH-1:0];
         lo <= q_step;
      end else if (state == IDLE) begin
         if (hi_we) hi <= wdata;
         if (lo_we) lo <= wdata;
      end
   end

   assign stall = (state == RUN);
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        flush;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          checks;
   int          errors;
   logic [63:0] exp_q[$];
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   booth_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .flush        (flush),
      .hi_we        (hi_we),
      .lo_we        (lo_we),
      .wdata        (wdata),
      .stall        (stall),
      .busy         (busy),
      .done         (done),
      .hi           (hi),
      .lo           (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
   endfunction

   // Drives a one-cycle start and records the expected product; returns at
   // the first negedge of the RUN state.
   task automatic issue(input logic [31:0] mc, input logic [31:0] mp, input bit expect_result);
      multiplicand = mc;
      multiplier   = mp;
      start        = 1'b1;
      if (expect_result) exp_q.push_back(smul(mc, mp));
      step();
      start = 1'b0;
   endtask

   // Waits for done (bounded), checks latency, stall width and the product.
   task automatic wait_done(input string tag, input int exp_n);
      int          n;
      int          stall_n;
      logic [63:0] expv;
      n       = 0;
      stall_n = 0;
      while (!done && n < 100) begin
         if (stall) stall_n++;
         step();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_n));
      chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_n));
      chk({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         chk({tag, "_product"}, {hi, lo}, expv);
         exp_hi = expv[63:32];
         exp_lo = expv[31:0];
      end
      chk({tag, "_done_stall"}, 64'(stall), 64'd0);
   endtask

   task automatic done_falls(input string tag);
      step();
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
      chk({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
   endtask

   initial begin
      int done_seen;
      checks       = 0;
      errors       = 0;
      exp_hi       = '0;
      exp_lo       = '0;
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      flush        = 1'b0;
      hi_we        = 1'b0;
      lo_we        = 1'b0;
      wdata        = '0;

      #3;
      chk("reset_state", {61'd0, stall, busy, done}, 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // 3 x 5
      issue(32'd3, 32'd5, 1'b1);
      chk("m3x5_stall_on", 64'(stall), 64'd1);
      wait_done("m3x5", 32);
      chk("m3x5_value", {hi, lo}, 64'h00000000_0000000F);
      done_falls("m3x5");

      // -7 x 6 with a stray start mid-run that must not reload operands
      issue(32'hFFFFFFF9, 32'h00000006, 1'b1);
      repeat (4) step();
      multiplicand = 32'h00000055;
      multiplier   = 32'h00000077;
      start        = 1'b1;
      step();
      start = 1'b0;
      wait_done("m7x6", 27);
      chk("m7x6_value", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
      done_falls("m7x6");

      // Most negative operand
      issue(32'h80000000, 32'h80000000, 1'b1);
      wait_done("mmin_sq", 32);
      chk("mmin_sq_value", {hi, lo}, 64'h40000000_00000000);
      done_falls("mmin_sq");

      issue(32'h80000000, 32'h00000001, 1'b1);
      wait_done("mmin_x1", 32);
      chk("mmin_x1_value", {hi, lo}, 64'hFFFFFFFF_80000000);
      // start+flush+hi_we in DONE: flush wins, write ignored
      start        = 1'b1;
      flush        = 1'b1;
      hi_we        = 1'b1;
      wdata        = 32'hCAFEF00D;
      multiplicand = 32'd9;
      multiplier   = 32'd9;
      step();
      start = 1'b0;
      flush = 1'b0;
      hi_we = 1'b0;
      chk("done_flush_busy", 64'(busy), 64'd0);
      chk("done_flush_hold", {hi, lo}, {exp_hi, exp_lo});

      // start+flush in IDLE: no load
      start = 1'b1;
      flush = 1'b1;
      step();
      start = 1'b0;
      flush = 1'b0;
      chk("idle_flush_busy", 64'(busy), 64'd0);

      // MTLO in IDLE, then flushed multiply with hi_we during RUN
      lo_we = 1'b1;
      wdata = 32'h00001234;
      step();
      lo_we  = 1'b0;
      exp_lo = 32'h00001234;
      chk("mtlo", {hi, lo}, {exp_hi, exp_lo});
      issue(32'd2, 32'd2, 1'b0);
      hi_we = 1'b1;
      wdata = 32'hDEADBEEF;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      hi_we = 1'b0;
      chk("flush_idle", {62'd0, stall, busy}, 64'd0);
      done_seen = 0;
      repeat (40) begin
         if (done) done_seen++;
         step();
      end
      chk("flush_no_done", 64'(done_seen), 64'd0);
      chk("flush_hilo", {hi, lo}, {exp_hi, exp_lo});

      // Back-to-back: start held during DONE
      issue(32'h00000007, 32'hFFFFFFFD, 1'b1);
      wait_done("b2b_first", 32);
      chk("b2b_first_value", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      chk("b2b_rerun", {62'd0, stall, busy}, 64'd3);
      wait_done("b2b_second", 32);
      chk("b2b_second_value", {hi, lo}, 64'h00000000_00000001);
      done_falls("b2b_second");

      // Async reset in the middle of a run
      issue(32'h00001234, 32'h00000010, 1'b0);
      repeat (14) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ctrl", {61'd0, stall, busy, done}, 64'd0);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      exp_hi = '0;
      exp_lo = '0;
      step();
      rst_n = 1'b1;
      step();
      issue(32'd3, 32'd5, 1'b1);
      wait_done("post_rst", 32);
      chk("post_rst_value", {hi, lo}, 64'h00000000_0000000F);
      done_falls("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Multi-cycle sequencer for the signed radix-2 Booth multiplier in the execute stage of the 32-bit pipelined MIPS core.
- Accepts MULT operands read by Decode (Read_Data_1 × Read_Data_2).
- Iterates one Booth step per clock and holds the pipeline with a stall while running.
- Commits the 64-bit product to the HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  MULT issued; operands valid this cycle
multiplicand  in  WIDTH  M operand (rs)
multiplier  in  WIDTH  Q operand (rt)
flush  in  1  pipeline flush; aborts an in-flight multiply
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
stall  out  1  hold IF/ID/EX; high while state==RUN
busy  out  1  high in RUN or DONE
done  out  1  one-cycle pulse when product is committed
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; A, Q, Q_1, M, cnt cleared.
  - hi=0, lo=0, stall=0, busy=0, done=0.
- States: IDLE, RUN, DONE (encoding in package).
- IDLE:
  - start=1 && flush=0 → load A=0 (WIDTH+1 bits), Q=multiplier, Q_1=0, M=sign-extend(multiplicand) to WIDTH+1, cnt=0; next state RUN.
  - hi_we/lo_we write wdata into hi/lo only in IDLE.
- RUN, per cycle:
  - {Q[0],Q_1}=01 → A=A+M; 10 → A=A−M; 00/11 → A unchanged. Arithmetic is WIDTH+1 bits, two's complement, so no overflow for M=−2^(WIDTH−1).
  - Then arithmetic right shift {A,Q,Q_1} by 1, replicating A's MSB.
  - cnt increments each cycle; after WIDTH iterations (cnt==WIDTH−1 step) next state DONE.
- DONE (one cycle):
  - hi=A[WIDTH−1:0], lo=Q registered at entry to DONE, so hi/lo and done appear together.
  - done=1, stall=0.
  - start=1 here → reload and go to RUN (back-to-back MULT); otherwise → IDLE.
- Latency:
  - start sampled at edge t0; stall high for cycles t0+1 .. t0+WIDTH.
  - done and new hi/lo visible at t0+WIDTH+1.
- start in RUN: ignored. Decode is stalled, so a legal pipeline never does this; the bench checks operands are not reloaded.
- flush:
  - In RUN: → IDLE next edge; hi/lo keep their old values; no done.
  - flush with start in IDLE or DONE: flush wins, no load.
- hi_we/lo_we during RUN/DONE: ignored; the multiply result has priority.
- Reset mid-RUN: immediate return to the reset values above.
- stall is a registered decode of state; no combinational path from start.

Decomposition:
- Shared package mips_pkg: WIDTH constant (32), state enum IDLE/RUN/DONE, Booth pair constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10).
- One natural sub-module: booth_step. Combinational: takes A, Q, Q_1, M and returns the next A, Q, Q_1 after add/sub and arithmetic shift. Instantiated once in RUN logic.

Test Plan:
- Reset then start with 3 × 5 → stall high 32 cycles; done at start+33; hi=0x00000000, lo=0x0000000F.
- −7 × 6 (0xFFFFFFF9, 0x00000006) → hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000; also 0x80000000 × 0x00000001 → hi=0xFFFFFFFF, lo=0x80000000.
- MTLO 0x1234 in IDLE, start 2 × 2, flush at cycle 10 → state IDLE next cycle; no done; lo stays 0x00001234; hi_we during RUN ignored.
- Back-to-back: start held in DONE with 0xFFFFFFFF × 0xFFFFFFFF → second done 33 cycles later; hi=0, lo=1; first result valid at the first done pulse.
- rst_n low at cycle 15 of RUN → stall, busy, hi, lo all 0 asynchronously; next start behaves normally.
